serial_addsub_ctrl: RTL

SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

---
 rtl/serial_addsub_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract unit: one full adder processes one operand bit per clock, LSB first,
// with a valid/ready result handshake.
module serial_addsub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             op_q, op_d;
  logic             carry_q, carry_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  // Single full adder; subtract is a + ~b + 1, the +1 coming from the carry preload.
  logic fa_a, fa_b, fa_sum, fa_cout;

  always_comb begin
    fa_a    = a_q[idx_q];
    fa_b    = b_q[idx_q] ^ op_q;
    fa_sum  = fa_a ^ fa_b ^ carry_q;
    fa_cout = (fa_a & fa_b) | (fa_a & carry_q) | (fa_b & carry_q);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          carry_d = op;
          idx_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        sum_d[idx_q] = fa_sum;
        carry_d      = fa_cout;
        idx_d        = idx_q + IdxW'(1);
        if (idx_q == LastIdx) begin
          cout_d  = fa_cout;
          // carry_q is the carry into the MSB at this point
          ovf_d   = carry_q ^ fa_cout;
          idx_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (result_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready        = (state_q == StIdle);
  assign result_valid = (state_q == StDone);
  assign sum          = sum_q;
  assign cout         = cout_q;
  assign overflow     = ovf_q;

endmodule
